// File: rtl/display_arb_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
package display_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } arb_state_t;

    localparam int DIGITS_W = 16;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } digits_t;

    // Index of the most significant set bit; 0 when the vector is empty.
    function automatic int unsigned highest_set(input logic [31:0] vec);
        highest_set = 0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) highest_set = unsigned'(i);
        end
    endfunction

endpackage

// File: rtl/display_arbiter_hold_timer.sv
// Hold-time counter: cleared by load, counts while enabled, saturates at HOLD_CYCLES-1.
module hold_timer #(
    parameter int HOLD_CYCLES = 200_000_000,
    parameter int CW          = $clog2(HOLD_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expire
);

    logic [CW-1:0] cnt;

    assign expire = (cnt == CW'(HOLD_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Multiplexes live reaction-test digits and prioritised transient messages onto
// the single seven-segment driver, holding each message for HOLD_CYCLES.
module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int NMSG        = 2,
    parameter int HOLD_CYCLES = 200_000_000,
    parameter int CW          = $clog2(HOLD_CYCLES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DIGITS_W-1:0]      live_digits_i,
    input  logic                     live_ltr_i,
    input  logic [NMSG-1:0]          msg_req_i,
    input  logic [DIGITS_W*NMSG-1:0] msg_digits_i,
    input  logic [NMSG-1:0]          msg_ltr_i,
    output logic [DIGITS_W-1:0]      digits_o,
    output logic                     ltr_o,
    output logic [NMSG-1:0]          active_o,
    output logic                     busy_o,
    output logic [NMSG-1:0]          done_o
);

    localparam int IW = (NMSG > 1) ? $clog2(NMSG) : 1;

    arb_state_t      state, state_nx;
    logic [IW-1:0]   cur, cur_nx, top;
    logic [NMSG-1:0] pending, pending_nx;
    digits_t         data_q [NMSG];
    logic [NMSG-1:0] ltr_q;

    logic            expire, expire_now, grant, timer_load;
    digits_t         digits_nx;
    logic            ltr_nx;
    logic [NMSG-1:0] active_nx, done_nx;
    logic            busy_nx;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES),
        .CW         (CW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .enable(state == SHOW),
        .expire(expire)
    );

    // A re-request from the shown source on its final cycle cancels the expiry.
    always_comb begin
        expire_now = (state == SHOW) && expire && !msg_req_i[cur];
        pending_nx = pending | msg_req_i;
        if (expire_now) pending_nx[cur] = 1'b0;
        top = IW'(highest_set(32'(pending_nx)));

        grant    = 1'b0;
        state_nx = state;
        cur_nx   = cur;
        done_nx  = '0;
        case (state)
            IDLE:    grant = |pending_nx;
            SHOW:    grant = expire_now ? (|pending_nx) : msg_req_i[top];
            default: grant = 1'b0;
        endcase

        if (grant) begin
            state_nx = SHOW;
            cur_nx   = top;
        end else if (expire_now) begin
            state_nx = IDLE;
        end

        if (expire_now) done_nx[cur] = 1'b1;
        timer_load = grant || (state_nx == IDLE);

        active_nx = '0;
        if (state_nx == SHOW) begin
            active_nx[cur_nx] = 1'b1;
            if (msg_req_i[cur_nx]) begin
                digits_nx = digits_t'(msg_digits_i[DIGITS_W*cur_nx +: DIGITS_W]);
                ltr_nx    = msg_ltr_i[cur_nx];
            end else begin
                digits_nx = data_q[cur_nx];
                ltr_nx    = ltr_q[cur_nx];
            end
        end else begin
            digits_nx = digits_t'(live_digits_i);
            ltr_nx    = live_ltr_i;
        end
        busy_nx = (state_nx == SHOW) || (|pending_nx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur      <= '0;
            pending  <= '0;
            digits_o <= '0;
            ltr_o    <= 1'b0;
            active_o <= '0;
            busy_o   <= 1'b0;
            done_o   <= '0;
        end else begin
            state    <= state_nx;
            cur      <= cur_nx;
            pending  <= pending_nx;
            digits_o <= digits_nx;
            ltr_o    <= ltr_nx;
            active_o <= active_nx;
            busy_o   <= busy_nx;
            done_o   <= done_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NMSG; k++) data_q[k] <= '0;
            ltr_q <= '0;
        end else begin
            for (int k = 0; k < NMSG; k++) begin
                if (msg_req_i[k]) begin
                    data_q[k] <= digits_t'(msg_digits_i[DIGITS_W*k +: DIGITS_W]);
                    ltr_q[k]  <= msg_ltr_i[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed, table-driven bench for display_arbiter with HOLD_CYCLES=10, NMSG=2.
module tb_display_arbiter;

    localparam logic [15:0] LIVE = 16'h1234;
    localparam logic [15:0] JUNK = 16'hF00D;

    logic        clk;
    logic        rst;
    logic [15:0] live_digits_i;
    logic        live_ltr_i;
    logic [1:0]  msg_req_i;
    logic [31:0] msg_digits_i;
    logic [1:0]  msg_ltr_i;
    logic [15:0] digits_o;
    logic        ltr_o;
    logic [1:0]  active_o;
    logic        busy_o;
    logic [1:0]  done_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  req;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  mltr;
        logic [15:0] exp_digits;
        logic        exp_ltr;
        logic [1:0]  exp_active;
        logic        exp_busy;
        logic [1:0]  exp_done;
    } vec_t;

    vec_t vecs[$];

    display_arbiter #(
        .NMSG       (2),
        .HOLD_CYCLES(10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .live_digits_i(live_digits_i),
        .live_ltr_i   (live_ltr_i),
        .msg_req_i    (msg_req_i),
        .msg_digits_i (msg_digits_i),
        .msg_ltr_i    (msg_ltr_i),
        .digits_o     (digits_o),
        .ltr_o        (ltr_o),
        .active_o     (active_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add_req(input logic [1:0] req, input logic [15:0] d0,
                                    input logic [15:0] d1, input logic [1:0] ml,
                                    input logic [15:0] ed, input logic el,
                                    input logic [1:0] ea, input logic eb,
                                    input logic [1:0] edn);
        vec_t v;
        v.req = req; v.d0 = d0; v.d1 = d1; v.mltr = ml;
        v.exp_digits = ed; v.exp_ltr = el; v.exp_active = ea;
        v.exp_busy = eb; v.exp_done = edn;
        vecs.push_back(v);
    endfunction

    // Idle cycles drive junk on the message buses so stray captures show up.
    function automatic void add_idle(input int n, input logic [15:0] ed, input logic el,
                                     input logic [1:0] ea, input logic eb,
                                     input logic [1:0] edn);
        for (int i = 0; i < n; i++) add_req(2'b00, JUNK, JUNK, 2'b11, ed, el, ea, eb, edn);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] ed, input logic el,
                               input logic [1:0] ea, input logic eb, input logic [1:0] edn);
        total++;
        if ({digits_o, ltr_o, active_o, busy_o, done_o} !== {ed, el, ea, eb, edn}) begin
            bad++;
            $display("[TB] FAIL %s: got digits=%h ltr=%b active=%b busy=%b done=%b, want digits=%h ltr=%b active=%b busy=%b done=%b",
                     name, digits_o, ltr_o, active_o, busy_o, done_o, ed, el, ea, eb, edn);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        msg_req_i    = v.req;
        msg_digits_i = {v.d1, v.d0};
        msg_ltr_i    = v.mltr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        live_digits_i = '0;
        live_ltr_i    = 1'b0;
        msg_req_i     = '0;
        msg_digits_i  = '0;
        msg_ltr_i     = '0;
        #1;
        checkOutput("reset_state", 16'h0000, 1'b0, 2'b00, 1'b0, 2'b00);

        @(negedge clk);
        rst           = 1'b0;
        live_digits_i = LIVE;
        @(posedge clk);
        #1;
        checkOutput("live_follow", LIVE, 1'b0, 2'b00, 1'b0, 2'b00);

        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset", 16'h0000, 1'b0, 2'b00, 1'b0, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("live_after_reset", LIVE, 1'b0, 2'b00, 1'b0, 2'b00);

        // single message from source 0
        add_req(2'b01, 16'hBEEF, JUNK, 2'b00, 16'hBEEF, 1'b0, 2'b01, 1'b1, 2'b00);
        add_idle(9, 16'hBEEF, 1'b0, 2'b01, 1'b1, 2'b00);
        add_idle(1, LIVE, 1'b0, 2'b00, 1'b0, 2'b01);
        add_idle(1, LIVE, 1'b0, 2'b00, 1'b0, 2'b00);

        // preemption of source 0 by source 1 three cycles in
        add_req(2'b01, 16'hAAAA, JUNK, 2'b00, 16'hAAAA, 1'b0, 2'b01, 1'b1, 2'b00);
        add_idle(2, 16'hAAAA, 1'b0, 2'b01, 1'b1, 2'b00);
        add_req(2'b10, JUNK, 16'h5555, 2'b10, 16'h5555, 1'b1, 2'b10, 1'b1, 2'b00);
        add_idle(9, 16'h5555, 1'b1, 2'b10, 1'b1, 2'b00);
        add_idle(1, 16'hAAAA, 1'b0, 2'b01, 1'b1, 2'b10);
        add_idle(9, 16'hAAAA, 1'b0, 2'b01, 1'b1, 2'b00);
        add_idle(1, LIVE, 1'b0, 2'b00, 1'b0, 2'b01);
        add_idle(1, LIVE, 1'b0, 2'b00, 1'b0, 2'b00);

        // simultaneous requests
        add_req(2'b11, 16'h1111, 16'h2222, 2'b01, 16'h2222, 1'b0, 2'b10, 1'b1, 2'b00);
        add_idle(9, 16'h2222, 1'b0, 2'b10, 1'b1, 2'b00);
        add_idle(1, 16'h1111, 1'b1, 2'b01, 1'b1, 2'b10);
        add_idle(9, 16'h1111, 1'b1, 2'b01, 1'b1, 2'b00);
        add_idle(1, LIVE, 1'b0, 2'b00, 1'b0, 2'b01);
        add_idle(1, LIVE, 1'b0, 2'b00, 1'b0, 2'b00);

        // re-request on the final hold cycle restarts without a done pulse
        add_req(2'b01, 16'h3333, JUNK, 2'b00, 16'h3333, 1'b0, 2'b01, 1'b1, 2'b00);
        add_idle(9, 16'h3333, 1'b0, 2'b01, 1'b1, 2'b00);
        add_req(2'b01, 16'h4444, JUNK, 2'b00, 16'h4444, 1'b0, 2'b01, 1'b1, 2'b00);
        add_idle(9, 16'h4444, 1'b0, 2'b01, 1'b1, 2'b00);
        add_idle(1, LIVE, 1'b0, 2'b00, 1'b0, 2'b01);
        add_idle(1, LIVE, 1'b0, 2'b00, 1'b0, 2'b00);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_digits, vecs[i].exp_ltr,
                        vecs[i].exp_active, vecs[i].exp_busy, vecs[i].exp_done);
        end

        // reset while showing source 1 with source 0 pending
        begin
            vec_t v;
            v.req = 2'b11; v.d0 = 16'h7777; v.d1 = 16'h8888; v.mltr = 2'b00;
            v.exp_digits = '0; v.exp_ltr = 1'b0; v.exp_active = '0;
            v.exp_busy = 1'b0; v.exp_done = '0;
            applyStimulus(v);
            checkOutput("rst_show_start", 16'h8888, 1'b0, 2'b10, 1'b1, 2'b00);
            v.req = 2'b00; v.d0 = JUNK; v.d1 = JUNK;
            applyStimulus(v);
            applyStimulus(v);
            checkOutput("rst_show_hold", 16'h8888, 1'b0, 2'b10, 1'b1, 2'b00);
            #2 rst = 1'b1;
            #1;
            checkOutput("rst_show_async", 16'h0000, 1'b0, 2'b00, 1'b0, 2'b00);
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 14; i++) begin
                applyStimulus(v);
                checkOutput($sformatf("rst_show_live%0d", i), LIVE, 1'b0, 2'b00, 1'b0, 2'b00);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
